// File: rtl/control_sequencer_if.sv
// Control bus between the T-state sequencer and the datapath: run enable and
// IR decode lines in, datapath strobes, ALU opcode and debug status out.
interface control_sequencer_if #(
   parameter int OPW = 3,
   parameter int SW  = 4
);
   logic           run_en;
   logic           dec_ld;
   logic           dec_add;
   logic           dec_sub;
   logic           dec_and;
   logic           dec_or;
   logic           dec_xor;
   logic           dec_shl;
   logic           dec_halt;
   logic           epc;
   logic           cpc;
   logic           imar;
   logic           eram;
   logic           iir;
   logic           ia;
   logic           ib;
   logic           ealu;
   logic [OPW-1:0] alu_op;
   logic           halted;
   logic [SW-1:0]  state;

   modport master (
      input  run_en, dec_ld, dec_add, dec_sub, dec_and, dec_or, dec_xor,
             dec_shl, dec_halt,
      output epc, cpc, imar, eram, iir, ia, ib, ealu, alu_op, halted, state
   );

   modport slave (
      output run_en, dec_ld, dec_add, dec_sub, dec_and, dec_or, dec_xor,
             dec_shl, dec_halt,
      input  epc, cpc, imar, eram, iir, ia, ib, ealu, alu_op, halted, state
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired T-state controller for the model computer: fetches an opcode,
// samples the IR decode lines and steps the per-instruction micro-sequence.
module control_sequencer #(
   parameter int OPW = 3,
   parameter int SW  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   control_sequencer_if.master  bus
);

   typedef enum logic [SW-1:0] {
      S_IDLE = SW'(0),
      S_FA   = SW'(1),
      S_FD   = SW'(2),
      S_DEC  = SW'(3),
      S_OA   = SW'(4),
      S_OR   = SW'(5),
      S_EX   = SW'(6),
      S_HLT  = SW'(7)
   } state_t;

   typedef struct packed {
      logic epc;
      logic cpc;
      logic imar;
      logic eram;
      logic iir;
      logic ia;
      logic ib;
      logic ealu;
   } strobe_t;

   localparam logic [OPW-1:0] OP_ADD = OPW'(0);
   localparam logic [OPW-1:0] OP_SUB = OPW'(1);
   localparam logic [OPW-1:0] OP_AND = OPW'(2);
   localparam logic [OPW-1:0] OP_OR  = OPW'(3);
   localparam logic [OPW-1:0] OP_XOR = OPW'(4);
   localparam logic [OPW-1:0] OP_SHL = OPW'(5);

   state_t         state;
   logic [OPW-1:0] alu_op;
   logic           is_ld;
   strobe_t        strb;

   // Decode is sampled only in DEC; the class is kept in is_ld because the IR
   // lines may already describe something else by the time OR executes.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register updating from the
      // pre-edge values, so ordering inside this block cannot create races.
      if (!rst_n) begin
         state  <= S_IDLE;
         alu_op <= '0;
         is_ld  <= 1'b0;
      end else if (bus.run_en) begin
         unique case (state)
            S_IDLE: state <= S_FA;
            S_FA:   state <= S_FD;
            S_FD:   state <= S_DEC;
            S_DEC: begin
               if (bus.dec_halt) begin
                  state <= S_HLT;
               end else if (bus.dec_ld) begin
                  state <= S_OA;
                  is_ld <= 1'b1;
               end else if (bus.dec_add) begin
                  state  <= S_OA;
                  is_ld  <= 1'b0;
                  alu_op <= OP_ADD;
               end else if (bus.dec_sub) begin
                  state  <= S_OA;
                  is_ld  <= 1'b0;
                  alu_op <= OP_SUB;
               end else if (bus.dec_and) begin
                  state  <= S_OA;
                  is_ld  <= 1'b0;
                  alu_op <= OP_AND;
               end else if (bus.dec_or) begin
                  state  <= S_OA;
                  is_ld  <= 1'b0;
                  alu_op <= OP_OR;
               end else if (bus.dec_xor) begin
                  state  <= S_OA;
                  is_ld  <= 1'b0;
                  alu_op <= OP_XOR;
               end else if (bus.dec_shl) begin
                  state  <= S_EX;
                  alu_op <= OP_SHL;
               end else begin
                  state <= S_FA;
               end
            end
            S_OA:   state <= S_OR;
            S_OR:   state <= is_ld ? S_FA : S_EX;
            S_EX:   state <= S_FA;
            S_HLT:  state <= S_HLT;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Strobes are gated by reset and pause so a held or aborted state never
   // leaks a partial transfer onto the datapath.
   always_comb begin
      // NOTE: default every output before the case so no path leaves a latch.
      strb = '0;
      if (rst_n && bus.run_en) begin
         unique case (state)
            S_FA: begin
               strb.epc  = 1'b1;
               strb.imar = 1'b1;
            end
            S_FD: begin
               strb.eram = 1'b1;
               strb.iir  = 1'b1;
               strb.cpc  = 1'b1;
            end
            S_OA: begin
               strb.epc  = 1'b1;
               strb.imar = 1'b1;
            end
            S_OR: begin
               strb.eram = 1'b1;
               strb.cpc  = 1'b1;
               strb.ia   = is_ld;
               strb.ib   = !is_ld;
            end
            S_EX: begin
               strb.ealu = 1'b1;
               strb.ia   = 1'b1;
            end
            default: strb = '0;
         endcase
      end
   end

   assign bus.epc    = strb.epc;
   assign bus.cpc    = strb.cpc;
   assign bus.imar   = strb.imar;
   assign bus.eram   = strb.eram;
   assign bus.iir    = strb.iir;
   assign bus.ia     = strb.ia;
   assign bus.ib     = strb.ib;
   assign bus.ealu   = strb.ealu;
   assign bus.alu_op = alu_op;
   assign bus.halted = (state == S_HLT);
   assign bus.state  = state;

endmodule
